// File: rtl/rf_wb_arbiter_if.sv
// Write-back bundle between the functional-unit sources, the arbiter and the
// register-file write-address decoder.
interface rf_wb_arbiter_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NR_SRC         = 3,
    parameter int unsigned NR_WRITE_PORTS = 2,
    parameter int unsigned ADDR_WIDTH     = 5
);
    logic [NR_SRC-1:0]                         src_valid_i;
    logic [NR_SRC-1:0][ADDR_WIDTH-1:0]         src_addr_i;
    logic [NR_SRC-1:0][DATA_WIDTH-1:0]         src_data_i;
    logic [NR_SRC-1:0]                         src_ready_o;
    logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_o;
    logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_o;
    logic [NR_WRITE_PORTS-1:0]                 we_o;

    // Arbiter side
    modport slave (
        input  src_valid_i, src_addr_i, src_data_i,
        output src_ready_o, waddr_o, wdata_o, we_o
    );

    // Source / register-file side
    modport master (
        output src_valid_i, src_addr_i, src_data_i,
        input  src_ready_o, waddr_o, wdata_o, we_o
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter: grants up to NR_WRITE_PORTS sources per cycle,
// drops writes to r0, never issues two writes to one register in a cycle.
module rf_wb_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NR_SRC         = 3,
    parameter int unsigned NR_WRITE_PORTS = 2,
    parameter int unsigned ADDR_WIDTH     = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    rf_wb_arbiter_if.slave    bus
);
    localparam int unsigned RR_W  = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
    localparam int unsigned CNT_W = $clog2(NR_WRITE_PORTS + 1);

    logic [RR_W-1:0]                           rr_q, rr_d;
    logic [NR_WRITE_PORTS-1:0]                 we_q, we_d;
    logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NR_SRC-1:0]                         ready_c;

    // Circular scan from rr_q; k-th non-r0, non-conflicting grant lands on port k
    always_comb begin
        logic [CNT_W-1:0] cnt;
        logic [RR_W-1:0]  sidx;
        logic [RR_W-1:0]  last;
        logic             any;
        logic             conflict;
        int unsigned      pos;

        ready_c  = '0;
        we_d     = '0;
        waddr_d  = '0;
        wdata_d  = '0;
        rr_d     = rr_q;
        cnt      = '0;
        sidx     = '0;
        last     = '0;
        any      = 1'b0;
        conflict = 1'b0;
        pos      = 0;

        for (int unsigned i = 0; i < NR_SRC; i++) begin
            pos = 32'(rr_q) + i;
            if (pos >= NR_SRC) pos = pos - NR_SRC;
            sidx = RR_W'(pos);
            if (bus.src_valid_i[sidx]) begin
                if (bus.src_addr_i[sidx] == '0) begin
                    ready_c[sidx] = 1'b1;
                end else begin
                    conflict = 1'b0;
                    for (int unsigned k = 0; k < NR_WRITE_PORTS; k++) begin
                        if (we_d[k] && (waddr_d[k] == bus.src_addr_i[sidx])) conflict = 1'b1;
                    end
                    if (!conflict && (32'(cnt) < NR_WRITE_PORTS)) begin
                        for (int unsigned k = 0; k < NR_WRITE_PORTS; k++) begin
                            if (32'(cnt) == k) begin
                                we_d[k]    = 1'b1;
                                waddr_d[k] = bus.src_addr_i[sidx];
                                wdata_d[k] = bus.src_data_i[sidx];
                            end
                        end
                        cnt           = cnt + CNT_W'(1);
                        ready_c[sidx] = 1'b1;
                        last          = sidx;
                        any           = 1'b1;
                    end
                end
            end
        end

        // Pointer moves past the last real grant; r0 drops leave it alone
        if (any) begin
            pos = 32'(last) + 1;
            if (pos >= NR_SRC) pos = 0;
            rr_d = RR_W'(pos);
        end
    end

    assign bus.src_ready_o = rst_ni ? ready_c : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q    <= '0;
            we_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            rr_q    <= rr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.we_o    = we_q;
    assign bus.waddr_o = waddr_q;
    assign bus.wdata_o = wdata_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter against a queue-based
// reference model of the grant rules.
module tb_rf_wb_arbiter;
    localparam int NS = 3;
    localparam int NP = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   m_rr;

    logic [NS-1:0]         o_rdy;
    logic [NP-1:0]         o_we;
    logic [NP-1:0][AW-1:0] o_wa;
    logic [NP-1:0][DW-1:0] o_wd;

    logic [NS-1:0]         e_rdy;
    logic [NP-1:0]         e_we;
    logic [NP-1:0][AW-1:0] e_wa;
    logic [NP-1:0][DW-1:0] e_wd;
    int                    e_rr;

    rf_wb_arbiter_if #(.DATA_WIDTH(DW), .NR_SRC(NS), .NR_WRITE_PORTS(NP), .ADDR_WIDTH(AW)) bus ();

    rf_wb_arbiter #(.DATA_WIDTH(DW), .NR_SRC(NS), .NR_WRITE_PORTS(NP), .ADDR_WIDTH(AW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: scan sources from rr, skip r0, refuse duplicates and full ports
    task automatic model(input logic [NS-1:0] v, input logic [NS-1:0][AW-1:0] a,
                         input logic [NS-1:0][DW-1:0] d, input int rr,
                         output logic [NS-1:0] rdy, output logic [NP-1:0] we,
                         output logic [NP-1:0][AW-1:0] wa, output logic [NP-1:0][DW-1:0] wd,
                         output int rr_n);
        logic [AW-1:0] used[$];
        rdy = '0; we = '0; wa = '0; wd = '0; rr_n = rr;
        for (int i = 0; i < NS; i++) begin
            int s = (rr + i) % NS;
            bit dup = 0;
            if (!v[s]) continue;
            if (a[s] == 0) begin rdy[s] = 1'b1; continue; end
            foreach (used[j]) if (used[j] == a[s]) dup = 1;
            if (dup || used.size() >= NP) continue;
            we[used.size()] = 1'b1;
            wa[used.size()] = a[s];
            wd[used.size()] = d[s];
            used.push_back(a[s]);
            rdy[s] = 1'b1;
            rr_n = (s + 1) % NS;
        end
    endtask

    // One cycle: ready sampled mid-cycle, registered outputs just after the edge
    task automatic tick();
        @(negedge clk);
        o_rdy = bus.src_ready_o;
        @(posedge clk);
        #1;
        o_we = bus.we_o;
        o_wa = bus.waddr_o;
        o_wd = bus.wdata_o;
    endtask

    task automatic predict();
        model(bus.src_valid_i, bus.src_addr_i, bus.src_data_i, m_rr, e_rdy, e_we, e_wa, e_wd, e_rr);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        bus.src_valid_i = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_rr = 0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.src_valid_i = 3'b111;
        bus.src_addr_i  = {5'd5, 5'd4, 5'd3};
        bus.src_data_i  = {32'h55, 32'h44, 32'h33};
        @(negedge clk);
        n_checks++; if (bus.src_ready_o !== 3'b000) $display("FAIL reset_ready: got %b want 000", bus.src_ready_o); else n_pass++;
        n_checks++; if (bus.we_o !== 2'b00) $display("FAIL reset_we: got %b want 00", bus.we_o); else n_pass++;
        n_checks++; if (bus.waddr_o !== '0 || bus.wdata_o !== '0) $display("FAIL reset_bus: got %h/%h want 0", bus.waddr_o, bus.wdata_o); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_rr = 0;
        tick();
        n_checks++; if (o_rdy !== 3'b011) $display("FAIL post_reset_ready: got %b want 011", o_rdy); else n_pass++;
        n_checks++; if (o_we !== 2'b11) $display("FAIL post_reset_we: got %b want 11", o_we); else n_pass++;
        n_checks++; if (o_wa[1] !== 5'd4 || o_wa[0] !== 5'd3) $display("FAIL post_reset_waddr: got %0d,%0d want 4,3", o_wa[1], o_wa[0]); else n_pass++;
        bus.src_valid_i = '0;
    endtask

    task automatic test_round_robin();
        int gcnt[NS];
        int rdy_exp[3];
        int rr_exp[3];
        rdy_exp = '{3, 5, 6};
        rr_exp  = '{2, 1, 0};
        foreach (gcnt[i]) gcnt[i] = 0;
        do_reset();
        bus.src_valid_i = 3'b111;
        bus.src_addr_i  = {5'd3, 5'd2, 5'd1};
        for (int c = 0; c < 3; c++) begin
            bus.src_data_i = {$urandom(), $urandom(), $urandom()};
            predict();
            tick();
            m_rr = e_rr;
            n_checks++; if (o_rdy !== 3'(rdy_exp[c])) $display("FAIL rr_ready c%0d: got %b want %b", c, o_rdy, 3'(rdy_exp[c])); else n_pass++;
            n_checks++; if (int'(dut.rr_q) !== rr_exp[c]) $display("FAIL rr_ptr c%0d: got %0d want %0d", c, dut.rr_q, rr_exp[c]); else n_pass++;
            n_checks++; if (o_we !== e_we || o_wa !== e_wa || o_wd !== e_wd) $display("FAIL rr_ports c%0d: got %b/%h/%h want %b/%h/%h", c, o_we, o_wa, o_wd, e_we, e_wa, e_wd); else n_pass++;
            for (int s = 0; s < NS; s++) if (o_rdy[s]) gcnt[s]++;
        end
        n_checks++; if (gcnt[0] != 2 || gcnt[1] != 2 || gcnt[2] != 2) $display("FAIL rr_fair: got %0d,%0d,%0d want 2,2,2", gcnt[0], gcnt[1], gcnt[2]); else n_pass++;
        bus.src_valid_i = '0;
    endtask

    task automatic test_addr0_drop();
        do_reset();
        bus.src_valid_i = 3'b111;
        bus.src_addr_i  = {5'd9, 5'd7, 5'd0};
        bus.src_data_i  = {32'h9999, 32'h7777, 32'h1111};
        tick();
        n_checks++; if (o_rdy !== 3'b111) $display("FAIL drop_ready: got %b want 111", o_rdy); else n_pass++;
        n_checks++; if (o_we !== 2'b11 || o_wa[0] !== 5'd7 || o_wa[1] !== 5'd9) $display("FAIL drop_ports: got %b %0d,%0d want 11 7,9", o_we, o_wa[0], o_wa[1]); else n_pass++;
        n_checks++; if (dut.rr_q !== 2'd0) $display("FAIL drop_rr: got %0d want 0", dut.rr_q); else n_pass++;
        bus.src_valid_i = '0;
    endtask

    task automatic test_same_addr();
        do_reset();
        bus.src_valid_i = 3'b011;
        bus.src_addr_i  = {5'd0, 5'd12, 5'd12};
        bus.src_data_i  = {32'h0, 32'hB, 32'hA};
        tick();
        n_checks++; if (o_rdy !== 3'b001) $display("FAIL conflict_ready: got %b want 001", o_rdy); else n_pass++;
        n_checks++; if (o_we !== 2'b01 || o_wd[0] !== 32'hA) $display("FAIL conflict_first: got %b %h want 01 a", o_we, o_wd[0]); else n_pass++;
        bus.src_valid_i = 3'b010;
        tick();
        n_checks++; if (o_rdy !== 3'b010) $display("FAIL conflict_ready2: got %b want 010", o_rdy); else n_pass++;
        n_checks++; if (o_we !== 2'b01 || o_wa[0] !== 5'd12 || o_wd[0] !== 32'hB) $display("FAIL conflict_second: got %b %0d %h want 01 12 b", o_we, o_wa[0], o_wd[0]); else n_pass++;
        bus.src_valid_i = '0;
    endtask

    task automatic test_single();
        do_reset();
        bus.src_valid_i = 3'b100;
        bus.src_addr_i  = {5'd31, 5'd0, 5'd0};
        bus.src_data_i  = {32'hDEADBEEF, 32'h0, 32'h0};
        tick();
        n_checks++; if (o_rdy !== 3'b100) $display("FAIL single_ready: got %b want 100", o_rdy); else n_pass++;
        n_checks++; if (o_we !== 2'b01 || o_wa[0] !== 5'd31 || o_wd[0] !== 32'hDEADBEEF) $display("FAIL single_port: got %b %0d %h want 01 31 deadbeef", o_we, o_wa[0], o_wd[0]); else n_pass++;
        n_checks++; if (dut.rr_q !== 2'd0) $display("FAIL single_rr: got %0d want 0", dut.rr_q); else n_pass++;
        bus.src_valid_i = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.src_valid_i = 3'b111;
        bus.src_addr_i  = {5'd3, 5'd2, 5'd1};
        bus.src_data_i  = {32'h3, 32'h2, 32'h1};
        tick();
        n_checks++; if (o_we !== 2'b11) $display("FAIL async_pre_we: got %b want 11", o_we); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.we_o !== 2'b00 || bus.waddr_o !== '0 || bus.wdata_o !== '0) $display("FAIL async_clear: got %b/%h/%h want 0", bus.we_o, bus.waddr_o, bus.wdata_o); else n_pass++;
        n_checks++; if (bus.src_ready_o !== 3'b000) $display("FAIL async_ready: got %b want 000", bus.src_ready_o); else n_pass++;
        bus.src_valid_i = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_rr = 0;
    endtask

    task automatic test_random();
        logic [NS-1:0] pv;
        pv = '0;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            for (int s = 0; s < NS; s++) begin
                if (!pv[s] && ($urandom_range(0, 9) < 7)) begin
                    pv[s] = 1'b1;
                    bus.src_addr_i[s] = AW'($urandom_range(0, 7));
                    bus.src_data_i[s] = $urandom();
                end
            end
            bus.src_valid_i = pv;
            predict();
            tick();
            m_rr = e_rr;
            n_checks++; if (o_rdy !== e_rdy) $display("FAIL rand_ready c%0d: got %b want %b", c, o_rdy, e_rdy); else n_pass++;
            n_checks++; if (o_we !== e_we || o_wa !== e_wa || o_wd !== e_wd) $display("FAIL rand_ports c%0d: got %b/%h/%h want %b/%h/%h", c, o_we, o_wa, o_wd, e_we, e_wa, e_wd); else n_pass++;
            n_checks++; if (int'(dut.rr_q) !== m_rr) $display("FAIL rand_rr c%0d: got %0d want %0d", c, dut.rr_q, m_rr); else n_pass++;
            n_checks++;
            if ((o_we[0] && o_wa[0] == 0) || (o_we[1] && o_wa[1] == 0) || (o_we == 2'b11 && o_wa[0] == o_wa[1]))
                $display("FAIL rand_contract c%0d: we %b waddr %h", c, o_we, o_wa);
            else n_pass++;
            pv = pv & ~e_rdy;
        end
        bus.src_valid_i = '0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_rr     = 0;
        rst_n    = 1'b0;
        bus.src_valid_i = '0;
        bus.src_addr_i  = '0;
        bus.src_data_i  = '0;
        test_reset();
        test_round_robin();
        test_addr0_drop();
        test_same_addr();
        test_single();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter sitting directly upstream of the register-file write-address decoder. It collects write-back requests from `NR_SRC` functional units, each with its own valid/ready handshake, and grants up to `NR_WRITE_PORTS` of them per cycle using a round-robin scheme. It drops writes to register 0 and prevents two ports from writing the same register in one cycle. Granted requests are registered and presented one cycle later on the `waddr_o`/`wdata_o`/`we_o` port bundle, which connects directly to the decoder's `waddr_i`/`wdata_i`/`we_i`.

## Interface
Parameters:
- `DATA_WIDTH`, 32: write data width.
- `NR_SRC`, 3: number of write-back sources; must be ≥1.
- `NR_WRITE_PORTS`, 2: register-file write ports; must be ≥1 and ≤ `NR_SRC`.
- `ADDR_WIDTH`, 5: register address width; register 0 is hard-wired zero.

Ports:
- `clk_i`, in, 1: clock; all state updates on rising edge.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `src_valid_i`, in, `[NR_SRC-1:0]`: request valid per source.
- `src_addr_i`, in, `[NR_SRC-1:0][ADDR_WIDTH-1:0]`: destination register per source.
- `src_data_i`, in, `[NR_SRC-1:0][DATA_WIDTH-1:0]`: write data per source.
- `src_ready_o`, out, `[NR_SRC-1:0]`: request accepted this cycle.
- `waddr_o`, out, `[NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]`: registered write address per port.
- `wdata_o`, out, `[NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]`: registered write data per port.
- `we_o`, out, `[NR_WRITE_PORTS-1:0]`: registered write enable per port.

## Operation
- Handshake rules:
  - A transfer occurs on a cycle where `src_valid_i[s]` and `src_ready_o[s]` are both 1.
  - A source holds valid, addr and data stable until accepted.
  - `src_ready_o` depends combinationally on `src_valid_i`/`src_addr_i` and `rr_q`. Sources must not make valid depend on ready.
- Round-robin pointer `rr_q` is in range 0..`NR_SRC-1`.
- Each cycle, sources are scanned in circular order `rr_q`, `rr_q+1`, …, mod `NR_SRC`. For each valid source:
  - Address 0: ready = 1. No port is consumed and nothing is forwarded (silent drop).
  - Address equal to one already granted this cycle: ready = 0. The source stalls.
  - Otherwise, if fewer than `NR_WRITE_PORTS` grants have been issued: ready = 1 and the source is assigned the next port. The k-th grant in scan order uses port k.
  - Otherwise: ready = 0.
- Next-state registers (on each clock edge):
  - Granted port k: `we_o[k]` ← 1, `waddr_o[k]` ← src addr, `wdata_o[k]` ← src data.
  - Port k without a grant: `we_o[k]` ← 0, `waddr_o[k]` ← 0, `wdata_o[k]` ← 0.
  - If at least one non-zero-address grant occurred: `rr_q` ← (index of last granted source in scan order + 1) mod `NR_SRC`.
  - If there was no such grant, `rr_q` is unchanged. Address-0 drops do not move `rr_q`.
- Valid outputs never violate the downstream contract:
  - No two set bits of `we_o` ever carry equal `waddr_o`.
  - `waddr_o` is never 0 where `we_o` = 1.
- Downstream always accepts, so there is no backpressure input. Throughput is `NR_WRITE_PORTS` writes per cycle.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system): `we_o` = 0, `waddr_o` = 0, `wdata_o` = 0, `rr_q` = 0.
- `src_ready_o` = 0 for all sources while `rst_ni` = 0.
- Latency: a request accepted in cycle N appears on the port outputs in cycle N+1, for exactly one cycle.
- Reset mid-operation: writes accepted in the cycle before reset asserts but not yet sampled by the register file are lost. Sources must treat reset as flushing all write-back.
- Fairness: a continuously valid source with a unique non-zero address is granted within `ceil(NR_SRC / NR_WRITE_PORTS)` cycles.

## Test plan
- Reset check: drive `rst_ni` = 0 with all sources valid at addr 3, 4, 5 → `src_ready_o` = 000 and `we_o` = 00. Release reset → the next cycle grants sources 0 and 1 to ports 0 and 1, and `we_o` = 11 one cycle later with `waddr_o` = {4, 3} (port1, port0).
- Round-robin: hold all 3 sources valid with addresses 1, 2, 3 → grants rotate {0,1}, {2,0}, {1,2}. Each source is granted twice in 3 cycles, and `rr_q` follows 0 → 2 → 1 → 0.
- Address-0 drop: source 0 addr 0, source 1 addr 7, source 2 addr 9, `rr_q` = 0 → `src_ready_o` = 111. Next cycle: `we_o` = 11, `waddr_o[0]` = 7, `waddr_o[1]` = 9, `rr_q` = 0.
- Same-address conflict: sources 0 and 1 both addr 12, data 0xA and 0xB, `rr_q` = 0 → only source 0 is ready. Next cycle: `we_o` = 01, `wdata_o[0]` = 0xA. Source 1 is granted on the following cycle with data 0xB.
- Single source: only source 2 valid, addr 31, data 0xDEADBEEF → ready the same cycle. Next cycle: `we_o` = 01, `waddr_o[0]` = 31, `wdata_o[0]` = 0xDEADBEEF, `rr_q` = 0.
- Async reset mid-stream: assert `rst_ni` between clock edges while `we_o` = 11 → `we_o`, `waddr_o`, `wdata_o` clear to 0 immediately, without waiting for a clock edge.
